// File: rtl/match_monitor_pkg.sv
// Shared state encodings and parameter defaults for the match monitor.
package match_monitor_pkg;
    localparam int CNT_W_DEF   = 8;
    localparam int STAMP_W_DEF = 16;
    localparam int WIN_DEF     = 16;
    localparam int THRESH_DEF  = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MONITOR = 2'd1;
    localparam logic [1:0] ST_ALARM   = 2'd2;
    localparam logic [1:0] ST_REARM   = 2'd3;
endpackage

// File: rtl/hit_window.sv
// Sliding window of the last WIN sampled bits with an incrementally maintained hit count.
module hit_window #(
    parameter int WIN = 16,
    localparam int HW = $clog2(WIN + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          shift_en,
    input  logic          bit_in,
    output logic [HW-1:0] hits,
    output logic [HW-1:0] hits_next
);
    logic [WIN-1:0] win;

    // Running count: add the incoming bit, drop the one falling off the end.
    always_comb begin
        hits_next = hits;
        if (shift_en)
            hits_next = hits + HW'(bit_in) - HW'(win[WIN-1]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win  <= '0;
            hits <= '0;
        end else if (clr) begin
            win  <= '0;
            hits <= '0;
        end else if (shift_en) begin
            win  <= {win[WIN-2:0], bit_in};
            hits <= hits_next;
        end
    end
endmodule

// File: rtl/match_monitor.sv
// Registers the detector pulse, keeps match statistics and a density alarm FSM.
module match_monitor
    import match_monitor_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int STAMP_W = STAMP_W_DEF,
    parameter int WIN     = WIN_DEF,
    parameter int THRESH  = THRESH_DEF,
    localparam int HW     = $clog2(WIN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               z_in,
    input  logic               enable,
    input  logic               clear,
    input  logic               ack,
    output logic [CNT_W-1:0]   match_count,
    output logic [STAMP_W-1:0] last_stamp,
    output logic [HW-1:0]      window_hits,
    output logic               alarm,
    output logic               overflow,
    output logic [1:0]         state
);
    logic               z_q;
    logic [STAMP_W-1:0] stamp;
    logic [HW-1:0]      hits_next;
    logic [1:0]         state_next;

    hit_window #(.WIN(WIN)) u_win (
        .clock     (clock),
        .reset     (reset),
        .clr       (clear),
        .shift_en  (enable),
        .bit_in    (z_q),
        .hits      (window_hits),
        .hits_next (hits_next)
    );

    // Transitions look at hits_next so the alarm lands on the same edge the window fills.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_next = ST_MONITOR;
                ST_MONITOR: if (hits_next >= HW'(THRESH)) state_next = ST_ALARM;
                ST_ALARM:   if (ack) state_next = ST_REARM;
                ST_REARM:   if (hits_next < HW'(THRESH)) state_next = ST_MONITOR;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            z_q         <= 1'b0;
            stamp       <= '0;
            match_count <= '0;
            last_stamp  <= '0;
            overflow    <= 1'b0;
            state       <= ST_IDLE;
            alarm       <= 1'b0;
        end else if (clear) begin
            z_q         <= 1'b0;
            stamp       <= '0;
            match_count <= '0;
            last_stamp  <= '0;
            overflow    <= 1'b0;
            state       <= enable ? ST_MONITOR : ST_IDLE;
            alarm       <= 1'b0;
        end else begin
            z_q   <= z_in;
            state <= state_next;
            alarm <= (state_next == ST_ALARM);
            if (enable) begin
                stamp <= stamp + STAMP_W'(1);
                if (z_q) begin
                    last_stamp <= stamp;
                    if (&match_count) overflow <= 1'b1;
                    else              match_count <= match_count + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_match_monitor.sv
// Directed and randomized checks of match_monitor against a queue-based reference model.
module tb_match_monitor;
    logic        clock, reset, z_in, enable, clear, ack;
    logic [7:0]  match_count;
    logic [15:0] last_stamp;
    logic [4:0]  window_hits;
    logic        alarm, overflow;
    logic [1:0]  state;
    logic [1:0]  s_count;
    logic [15:0] s_stamp;
    logic [4:0]  s_hits;
    logic        s_alarm, s_overflow;
    logic [1:0]  s_state;

    int checks = 0;
    int errors = 0;

    match_monitor dut (
        .clock(clock), .reset(reset), .z_in(z_in), .enable(enable), .clear(clear), .ack(ack),
        .match_count(match_count), .last_stamp(last_stamp), .window_hits(window_hits),
        .alarm(alarm), .overflow(overflow), .state(state)
    );

    match_monitor #(.CNT_W(2)) dut_small (
        .clock(clock), .reset(reset), .z_in(z_in), .enable(enable), .clear(clear), .ack(ack),
        .match_count(s_count), .last_stamp(s_stamp), .window_hits(s_hits),
        .alarm(s_alarm), .overflow(s_overflow), .state(s_state)
    );

    always #5 clock = ~clock;

    // Reference model: counts, last stamp and a queue holding the last 16 sampled bits.
    int m_cnt, m_cnt_s, m_stamp, m_last, m_st;
    bit m_ovf, m_ovf_s, m_zq, m_alm;
    bit m_win[$];

    function automatic int hits_of();
        int h = 0;
        foreach (m_win[i]) h += m_win[i];
        return h;
    endfunction

    task automatic model_zero();
        m_cnt = 0; m_cnt_s = 0; m_stamp = 0; m_last = 0;
        m_ovf = 0; m_ovf_s = 0; m_zq = 0; m_alm = 0;
        m_win.delete();
        repeat (16) m_win.push_back(1'b0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("match_count", 32'(match_count), m_cnt);
        chk("last_stamp",  32'(last_stamp),  m_last);
        chk("window_hits", 32'(window_hits), hits_of());
        chk("alarm",       32'(alarm),       32'(m_alm));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("state",       32'(state),       m_st);
        chk("small_count", 32'(s_count),     m_cnt_s);
        chk("small_ovf",   32'(s_overflow),  32'(m_ovf_s));
        chk("small_state", 32'(s_state),     m_st);
    endtask

    // Advance the model by one edge using the current inputs, then compare after the edge.
    task automatic step();
        int h;
        if (clear) begin
            model_zero();
            m_st = enable ? 1 : 0;
        end else begin
            if (enable) begin
                if (m_zq) begin
                    m_last = m_stamp;
                    if (m_cnt == 255) m_ovf = 1; else m_cnt++;
                    if (m_cnt_s == 3) m_ovf_s = 1; else m_cnt_s++;
                end
                m_stamp = (m_stamp + 1) % 65536;
                m_win.push_back(m_zq);
                void'(m_win.pop_front());
                h = hits_of();
                case (m_st)
                    0: m_st = 1;
                    1: if (h >= 3) m_st = 2;
                    2: if (ack) m_st = 3;
                    default: if (h < 3) m_st = 1;
                endcase
            end else begin
                m_st = 0;
            end
            m_zq  = z_in;
            m_alm = (m_st == 2);
        end
        @(posedge clock);
        #1;
        compare_all();
    endtask

    initial begin
        clock = 0; reset = 1; z_in = 0; enable = 0; clear = 0; ack = 0;
        model_zero();
        m_st = 0;
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        reset = 0;

        // Three pulses seven cycles apart trip the alarm on the edge after the third capture.
        enable = 1; clear = 1;
        step();
        clear = 0;
        for (int i = 1; i <= 18; i++) begin
            z_in = (i == 3 || i == 10 || i == 17);
            step();
            if (i == 4)  chk("stamp_first", 32'(last_stamp), 3);
            if (i == 11) chk("stamp_second", 32'(last_stamp), 10);
            if (i == 17) chk("no_alarm_at_two", 32'(alarm), 0);
        end
        chk("t2_count", 32'(match_count), 3);
        chk("t2_hits", 32'(window_hits), 3);
        chk("t2_stamp", 32'(last_stamp), 17);
        chk("t2_alarm", 32'(alarm), 1);

        // Acknowledge, then wait for the oldest pulse to leave the window.
        z_in = 0; ack = 1;
        step();
        ack = 0;
        chk("t5_rearm", 32'(state), 3);
        chk("t5_alarm_off", 32'(alarm), 0);
        step();
        chk("t5_monitor", 32'(state), 1);
        chk("t5_hits", 32'(window_hits), 2);
        repeat (10) step();
        chk("t5_no_realarm", 32'(alarm), 0);

        // Burst into alarm, then drop enable; pulses while disabled change nothing.
        for (int i = 0; i < 5; i++) begin
            z_in = (i < 3);
            step();
        end
        chk("t6_alarm", 32'(state), 2);
        enable = 0;
        step();
        chk("t6_idle", 32'(state), 0);
        chk("t6_alarm_off", 32'(alarm), 0);
        for (int i = 0; i < 8; i++) begin
            z_in = i[0];
            step();
        end

        // Asynchronous reset while alarmed.
        enable = 1; z_in = 1;
        repeat (4) step();
        chk("t1_pre_alarm", 32'(alarm), 1);
        #2 reset = 1;
        #1;
        chk("t1_count", 32'(match_count), 0);
        chk("t1_stamp", 32'(last_stamp), 0);
        chk("t1_hits", 32'(window_hits), 0);
        chk("t1_alarm", 32'(alarm), 0);
        chk("t1_state", 32'(state), 0);
        chk("t1_ovf", 32'(overflow), 0);
        model_zero();
        m_st = 0;
        reset = 0; z_in = 0;

        // Sparse pulses: window never holds more than one, no alarm, small counter saturates.
        clear = 1;
        step();
        clear = 0;
        for (int p = 0; p < 10; p++) begin
            z_in = 1;
            step();
            z_in = 0;
            repeat (19) begin
                step();
                chk("t3_hits_le1", 32'(window_hits <= 5'd1), 1);
            end
        end
        chk("t3_count", 32'(match_count), 10);
        chk("t3_alarm", 32'(alarm), 0);
        chk("t4_small_sat", 32'(s_count), 3);
        chk("t4_small_ovf", 32'(s_overflow), 1);
        clear = 1;
        step();
        clear = 0;
        chk("t4_clr_count", 32'(s_count), 0);
        chk("t4_clr_ovf", 32'(s_overflow), 0);
        chk("t4_clr_stamp", 32'(s_stamp), 0);

        // Randomized traffic including clear/ack collisions and enable drops.
        for (int i = 0; i < 600; i++) begin
            z_in   = ($urandom_range(0, 2) == 0);
            ack    = ($urandom_range(0, 7) == 0);
            enable = ($urandom_range(0, 19) != 0);
            clear  = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
